// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encoding
// and the byte-enable helper used by the store path.
package lsu_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_RESP = 2'b10
   } lsu_state_e;

   // Byte enables for an access of the given width at the given byte offset.
   function automatic logic [3:0] lsu_byte_enable(input logic [2:0] funct3,
                                                  input logic [1:0] offset);
      logic [3:0] be;
      case (funct3)
         F3_LB, F3_LBU: be = 4'b0001 << offset;
         F3_LH, F3_LHU: be = 4'b0011 << {offset[1], 1'b0};
         F3_LW:         be = 4'b1111;
         default:       be = 4'b0000;
      endcase
      return be;
   endfunction

   // True for the five funct3 codes that RV32I defines for loads.
   function automatic logic lsu_funct3_legal(input logic [2:0] funct3);
      logic ok;
      case (funct3)
         F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
         default:                             ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load formatter: picks the addressed byte/half out of a
// memory word and sign- or zero-extends it to 32 bits.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  offset_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] result_o
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Lane selection followed by width-dependent extension.
   always_comb begin
      byte_s = word_i[{offset_i, 3'b000} +: 8];
      half_s = word_i[{offset_i[1], 4'b0000} +: 16];
      case (funct3_i)
         F3_LB:   result_o = {{24{byte_s[7]}}, byte_s};
         F3_LBU:  result_o = {24'h000000, byte_s};
         F3_LH:   result_o = {{16{half_s[15]}}, half_s};
         F3_LHU:  result_o = {16'h0000, half_s};
         F3_LW:   result_o = word_i;
         default: result_o = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the RV32I execute stage and the data memory.
// Stores commit in the accept cycle and are acknowledged one cycle later;
// loads return formatted data two cycles after acceptance.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MISALIGN_TRAP = 1
)(
   input  logic        clk,
   input  logic        resetb,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_fault,
   output logic        mem_read_ready,
   output logic        mem_write_ready,
   output logic [29:0] mem_read_address,
   output logic [29:0] mem_write_address,
   output logic [31:0] mem_write_data,
   output logic [3:0]  mem_write_byte,
   input  logic [31:0] mem_read_data
);

   lsu_state_e  state_q, state_d;
   logic [1:0]  offset_q, offset_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] rdata_q, rdata_d;
   logic        fault_q, fault_d;

   logic        accept_s;
   logic        legal_s;
   logic        misaligned_s;
   logic        fault_s;
   logic [1:0]  offset_s;
   logic [31:0] align_s;
   logic [31:0] lanes_s;

   lsu_load_align u_align (
      .word_i   (mem_read_data),
      .offset_i (offset_q),
      .funct3_i (funct3_q),
      .result_o (align_s)
   );

   // Classify the incoming request: legality, misalignment and effective offset.
   always_comb begin
      legal_s      = lsu_funct3_legal(req_funct3);
      misaligned_s = 1'b0;
      offset_s     = req_addr[1:0];
      case (req_funct3)
         F3_LH, F3_LHU: begin
            misaligned_s = req_addr[0];
            if (MISALIGN_TRAP == 0) begin
               offset_s = {req_addr[1], 1'b0};
            end else begin
               offset_s = req_addr[1:0];
            end
         end
         F3_LW: begin
            misaligned_s = |req_addr[1:0];
            if (MISALIGN_TRAP == 0) begin
               offset_s = 2'b00;
            end else begin
               offset_s = req_addr[1:0];
            end
         end
         default: begin
            misaligned_s = 1'b0;
            offset_s     = req_addr[1:0];
         end
      endcase
      fault_s = ~legal_s | ((MISALIGN_TRAP != 0) & misaligned_s);
   end

   // Store lane replication by access width.
   always_comb begin
      case (req_funct3)
         F3_LB, F3_LBU: lanes_s = {4{req_wdata[7:0]}};
         F3_LH, F3_LHU: lanes_s = {2{req_wdata[15:0]}};
         default:       lanes_s = req_wdata;
      endcase
   end

   // Memory strobes are only raised for a fault-free request in its accept cycle.
   always_comb begin
      req_ready         = (state_q != ST_LOAD);
      accept_s          = req_valid & req_ready;
      mem_read_ready    = accept_s & ~req_we & ~fault_s;
      mem_write_ready   = accept_s & req_we & ~fault_s;
      mem_read_address  = req_addr[31:2];
      mem_write_address = req_addr[31:2];
      mem_write_data    = lanes_s;
      if (mem_write_ready) begin
         mem_write_byte = lsu_byte_enable(req_funct3, offset_s);
      end else begin
         mem_write_byte = 4'b0000;
      end
   end

   // Next-state and response formatting.
   always_comb begin
      state_d  = state_q;
      offset_d = offset_q;
      funct3_d = funct3_q;
      rdata_d  = rdata_q;
      fault_d  = fault_q;
      case (state_q)
         ST_IDLE, ST_RESP: begin
            if (accept_s) begin
               if (!req_we && !fault_s) begin
                  state_d  = ST_LOAD;
                  offset_d = offset_s;
                  funct3_d = req_funct3;
                  rdata_d  = 32'h0000_0000;
                  fault_d  = 1'b0;
               end else begin
                  state_d  = ST_RESP;
                  rdata_d  = 32'h0000_0000;
                  fault_d  = fault_s;
               end
            end else begin
               state_d = ST_IDLE;
               rdata_d = 32'h0000_0000;
               fault_d = 1'b0;
            end
         end
         ST_LOAD: begin
            state_d = ST_RESP;
            rdata_d = align_s;
            fault_d = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            rdata_d = 32'h0000_0000;
            fault_d = 1'b0;
         end
      endcase
   end

   // State and response registers.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state_q  <= ST_IDLE;
         offset_q <= 2'b00;
         funct3_q <= 3'b000;
         rdata_q  <= 32'h0000_0000;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         offset_q <= offset_d;
         funct3_q <= funct3_d;
         rdata_q  <= rdata_d;
         fault_q  <= fault_d;
      end
   end

   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_fault = fault_q;

endmodule
